// File: rtl/v_mac_seq_if.sv
// Sequencer <-> vector ALU lane-0 link: operand handshake, opcode out, result in.
`ifndef V_MAC_SEQ_DEFS
`define V_MAC_SEQ_DEFS
`define ALU_OP_BUS  [3:0]
`define VALU_OP_NOP 4'h0
`define VALU_OP_MAC 4'h3
`endif

interface v_mac_seq_if #(
    parameter int unsigned ACC_W = 32
);
    logic             src_valid_i;
    logic             src_ready_o;
    logic `ALU_OP_BUS valu_opcode_o;
    logic [ACC_W-1:0] valu_result_i;

    modport master (
        input  src_valid_i,
        input  valu_result_i,
        output src_ready_o,
        output valu_opcode_o
    );

    modport slave (
        output src_valid_i,
        output valu_result_i,
        input  src_ready_o,
        input  valu_opcode_o
    );
endinterface

// File: rtl/v_mac_seq.sv
// Multiply-accumulate sequencer: sums N lane-0 ALU results, then optionally
// requantizes the sum to int8 with rounding and saturation.
`ifndef V_MAC_SEQ_DEFS
`define V_MAC_SEQ_DEFS
`define ALU_OP_BUS  [3:0]
`define VALU_OP_NOP 4'h0
`define VALU_OP_MAC 4'h3
`endif

module v_mac_seq #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] beats_i,
    input  logic             mode_i,
    input  logic             abort_i,
    v_mac_seq_if.master      alu,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] result_o,
    output logic             sat_o
);

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [ACC_W-1:0]   result_d;
    logic               sat_d;
    logic               busy_d, done_d, ready_q, ready_d;
    logic `ALU_OP_BUS   opcode_q, opcode_d;
    logic signed [ACC_W-1:0] q_t, q_r;
    logic               accept;

    assign alu.src_ready_o   = ready_q;
    assign alu.valu_opcode_o = opcode_q;
    assign accept            = alu.src_valid_i & ready_q;

    // Round-half-up requantization of acc by 2^8, then int8 clip.
    always_comb begin
        q_t = ($signed(acc_q) >>> 7) + ACC_W'(1);
        q_r = q_t >>> 1;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        result_d = result_o;
        sat_d    = sat_o;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d  = '0;
                    mode_d = mode_i;
                    if (beats_i != '0) begin
                        cnt_d   = beats_i;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (accept) begin
                    acc_d = acc_q + ACC_W'(alu.valu_result_i);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIN;
                end
            end
            FIN: begin
                if (mode_q) begin
                    if (q_r > Q_MAX) begin
                        result_d = Q_MAX;
                        sat_d    = 1'b1;
                    end else if (q_r < Q_MIN) begin
                        result_d = Q_MIN;
                        sat_d    = 1'b1;
                    end else begin
                        result_d = q_r;
                        sat_d    = 1'b0;
                    end
                end else begin
                    result_d = acc_q;
                    sat_d    = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the next-state decode.
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        ready_d  = (state_d == RUN);
        opcode_d = ready_d ? `VALU_OP_MAC : `VALU_OP_NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            result_o <= '0;
            sat_o    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            ready_q  <= 1'b0;
            opcode_q <= `VALU_OP_NOP;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            result_o <= result_d;
            sat_o    <= sat_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            ready_q  <= ready_d;
            opcode_q <= opcode_d;
        end
    end

endmodule

// File: tb/tb_v_mac_seq.sv
// Directed bench for v_mac_seq: raw sums, requantization, valid gaps,
// zero length, abort, ignored start and asynchronous reset.
`ifndef V_MAC_SEQ_DEFS
`define V_MAC_SEQ_DEFS
`define ALU_OP_BUS  [3:0]
`define VALU_OP_NOP 4'h0
`define VALU_OP_MAC 4'h3
`endif

module tb_v_mac_seq;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] beats_i;
    logic             mode_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;
    logic [ACC_W-1:0] result_o;
    logic             sat_o;

    int n_assert = 0;
    int n_fail   = 0;

    v_mac_seq_if #(.ACC_W(ACC_W)) alu ();

    v_mac_seq #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .beats_i  (beats_i),
        .mode_i   (mode_i),
        .abort_i  (abort_i),
        .alu      (alu),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .sat_o    (sat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] v);
        alu.src_valid_i   = 1'b1;
        alu.valu_result_i = v;
        tick();
        alu.src_valid_i   = 1'b0;
    endtask

    // One-beat operation; start lands in IDLE, done two cycles after the beat.
    task automatic single(input string tag, input logic m, input logic [31:0] v,
                          input logic [31:0] exp_r, input logic exp_s);
        start_i = 1'b1; beats_i = 8'd1; mode_i = m;
        tick();
        start_i = 1'b0;
        beat(v);
        chk({tag, "_fin_done"}, done_o, 0);
        tick();
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_result"}, result_o, exp_r);
        chk({tag, "_sat"}, sat_o, exp_s);
        tick();
        chk({tag, "_done_low"}, done_o, 0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; beats_i = '0; mode_i = 1'b0; abort_i = 1'b0;
        alu.src_valid_i = 1'b0; alu.valu_result_i = '0;
        tick(); tick();
        chk("rst_busy",   busy_o, 0);
        chk("rst_done",   done_o, 0);
        chk("rst_ready",  alu.src_ready_o, 0);
        chk("rst_opcode", alu.valu_opcode_o, `VALU_OP_NOP);
        chk("rst_result", result_o, 0);
        chk("rst_sat",    sat_o, 0);
        rst = 1'b0;
        tick();

        // Raw sum 10 + 20 - 5
        start_i = 1'b1; beats_i = 8'd3; mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        chk("raw_busy",   busy_o, 1);
        chk("raw_ready",  alu.src_ready_o, 1);
        chk("raw_opcode", alu.valu_opcode_o, `VALU_OP_MAC);
        beat(32'd10);
        beat(32'd20);
        beat(-32'sd5);
        chk("raw_fin_done",   done_o, 0);
        chk("raw_fin_ready",  alu.src_ready_o, 0);
        chk("raw_fin_opcode", alu.valu_opcode_o, `VALU_OP_NOP);
        tick();
        chk("raw_done",   done_o, 1);
        chk("raw_result", result_o, 32'd25);
        chk("raw_sat",    sat_o, 0);
        tick();
        chk("raw_done_low", done_o, 0);
        chk("raw_idle",     busy_o, 0);

        // Requantization cases
        single("rq_384",  1'b1, 32'd384,     32'd2,         1'b0);
        single("rq_pos",  1'b1, 32'd100000,  32'd127,       1'b1);
        single("rq_neg",  1'b1, -32'sd40000, 32'hFFFFFF80,  1'b1);

        // Zero length
        start_i = 1'b1; beats_i = 8'd0; mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        chk("zl_ready", alu.src_ready_o, 0);
        chk("zl_busy",  busy_o, 1);
        chk("zl_done0", done_o, 0);
        tick();
        chk("zl_done",   done_o, 1);
        chk("zl_result", result_o, 32'd0);
        chk("zl_sat",    sat_o, 0);
        tick();

        // Valid gaps: 1,0,0,1 with 7,x,x,9
        start_i = 1'b1; beats_i = 8'd2; mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        beat(32'd7);
        alu.valu_result_i = 32'd123;
        tick();
        chk("gap_busy1",  busy_o, 1);
        chk("gap_ready1", alu.src_ready_o, 1);
        alu.valu_result_i = 32'd55;
        tick();
        chk("gap_busy2", busy_o, 1);
        beat(32'd9);
        chk("gap_fin_busy", busy_o, 1);
        tick();
        chk("gap_done",   done_o, 1);
        chk("gap_result", result_o, 32'd16);
        tick();

        // Start during RUN is ignored (would otherwise reload count and mode)
        start_i = 1'b1; beats_i = 8'd2; mode_i = 1'b0;
        tick();
        beats_i = 8'd9; mode_i = 1'b1;
        beat(32'd3);
        start_i = 1'b0;
        beat(32'd4);
        tick();
        chk("ign_done",   done_o, 1);
        chk("ign_result", result_o, 32'd7);
        chk("ign_sat",    sat_o, 0);
        tick();

        // Abort coincident with last of 4 beats
        start_i = 1'b1; beats_i = 8'd4; mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        beat(32'd1);
        beat(32'd2);
        beat(32'd3);
        abort_i = 1'b1;
        beat(32'd4);
        abort_i = 1'b0;
        chk("abt_busy",  busy_o, 0);
        chk("abt_ready", alu.src_ready_o, 0);
        chk("abt_done0", done_o, 0);
        tick();
        chk("abt_done1", done_o, 0);
        tick();
        chk("abt_done2", done_o, 0);
        chk("abt_result", result_o, 32'd7);

        // Asynchronous reset after 2 of 5 beats
        start_i = 1'b1; beats_i = 8'd5; mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        beat(32'd100);
        beat(32'd200);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy",   busy_o, 0);
        chk("ar_ready",  alu.src_ready_o, 0);
        chk("ar_opcode", alu.valu_opcode_o, `VALU_OP_NOP);
        chk("ar_result", result_o, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_done1", done_o, 0);
        tick();
        chk("ar_done2", done_o, 0);
        single("post_rst", 1'b0, 32'd5, 32'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
